// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate sequencer.
// Contents: op-code constants, FSM state encoding, default widths, op legality helper.
// The control unit imports the op codes from here when decoding shift instructions.
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic [2:0] OP_SHR  = 3'd0;  // logical right, zero fill
  localparam logic [2:0] OP_SHRA = 3'd1;  // arithmetic right, sign fill
  localparam logic [2:0] OP_SHL  = 3'd2;  // left, zero fill
  localparam logic [2:0] OP_ROR  = 3'd3;  // rotate right
  localparam logic [2:0] OP_ROL  = 3'd4;  // rotate left

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Codes 5..7 are illegal and behave as a zero-count pass-through.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One bit-position shift/rotate step, purely combinational.
// Ports: data (operand), op (operation code) -> stepped (data moved by one position).
// Illegal op codes pass data through unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] stepped
);

  always_comb begin
    stepped = data;
    case (op)
      OP_SHR:  stepped = {1'b0, data[WIDTH-1:1]};
      OP_SHRA: stepped = {data[WIDTH-1], data[WIDTH-1:1]};
      OP_SHL:  stepped = {data[WIDTH-2:0], 1'b0};
      OP_ROR:  stepped = {data[0], data[WIDTH-1:1]};
      OP_ROL:  stepped = {data[WIDTH-2:0], data[WIDTH-1]};
      default: stepped = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: one bit position per clock, done pulse when finished.
// Latency: done rises n edges after the start edge (n = in_b[CNT_W-1:0], 0 for illegal ops).
// Backpressure: none; start is only sampled in IDLE, requester waits for busy low.
// Ports: clock, clear (async active-high reset), start/op/in_a/in_b request inputs,
//        result (held between operations), busy (not IDLE), done (one-cycle result strobe).
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   data;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   stepped;
  logic [CNT_W-1:0]   start_cnt;
  logic               last_step;

  // Only the low count bits select the shift amount.
  logic               unused_in_b_hi;
  assign unused_in_b_hi = ^in_b[WIDTH-1:CNT_W];

  // Illegal ops are forced to zero count so they complete as a pass-through.
  assign start_cnt = op_legal(op) ? in_b[CNT_W-1:0] : '0;
  assign last_step = (cnt == CNT_W'(1));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data    (data),
    .op      (op_r),
    .stepped (stepped)
  );

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (start_cnt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_step) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs decode directly from the state register, so no input reaches them combinationally.
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Datapath: operand, counter, captured op and the held result.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      data   <= '0;
      cnt    <= '0;
      op_r   <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            data <= in_a;
            cnt  <= start_cnt;
            op_r <= op;
            if (start_cnt == '0) begin
              result <= in_a;
            end
          end
        end
        ST_SHIFT: begin
          data <= stepped;
          cnt  <= cnt - 1'b1;
          // The step taken on the final count goes straight into result.
          if (last_step) begin
            result <= stepped;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
